tsc: RTL and testbench

TSC -- requirements
Module: tsc

---
 rtl/tsc_pkg.sv | 17 +
 rtl/tsc_ring_buffer.sv | 44 ++++
 rtl/tsc.sv | 149 ++++++++++++++
 tb/tb_tsc.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared types and default constants for the triggered sample capture (TSC) block.
// Optional feature macro: TSC_EDGE_TRIG_EN (see tsc.sv).
package tsc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUNNING,
      TRIGGERED,
      DONE,
      SENDING
   } tscState_t;

   localparam int         TSC_DEFAULT_DEPTH      = 32;
   localparam logic [7:0] TSC_DEFAULT_TRIG_LEVEL = 8'hD0;
   localparam int         TSC_DEFAULT_POST_TRIG  = 16;

endpackage

// File: rtl/tsc_ring_buffer.sv
// Circular byte store for the TSC: one write port with a wrapping write pointer,
// and an asynchronous read port addressed relative to the write pointer so the
// sender can walk from the oldest byte (offset 0) to the newest (offset DEPTH-1).
module tsc_ring_buffer
   import tsc_pkg::*;
#(
   parameter int DEPTH = TSC_DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_wrEn,
   input  logic [7:0]               i_wrData,
   input  logic [$clog2(DEPTH)-1:0] i_rdOffset,
   output logic [$clog2(DEPTH)-1:0] o_wrPtr,
   output logic [7:0]               o_rdData
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] w_rdAddr;

   // Write pointer advances on every stored byte and wraps naturally at DEPTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
      end else if (i_wrEn) begin
         r_wrPtr <= r_wrPtr + AW'(1);
      end
   end

   // Storage itself is never cleared; stale bytes are simply overwritten.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[r_wrPtr] <= i_wrData;
      end
   end

   assign w_rdAddr = r_wrPtr + i_rdOffset;
   assign o_rdData = r_mem[w_rdAddr];
   assign o_wrPtr  = r_wrPtr;

endmodule

// File: rtl/tsc.sv
// TSC top: captures ADC samples into a ring buffer until a trigger plus a fixed
// number of post-trigger samples, then serialises the frozen buffer MSB-first,
// oldest byte first, on SD when SBF is requested.
// Optional feature macro: TSC_EDGE_TRIG_EN -- when defined the trigger needs a
// rising crossing (previous stored sample below the level); otherwise any stored
// sample at or above the level triggers.
module tsc
   import tsc_pkg::*;
#(
   parameter int         DEPTH      = TSC_DEFAULT_DEPTH,
   parameter logic [7:0] TRIG_LEVEL = TSC_DEFAULT_TRIG_LEVEL,
   parameter int         POST_TRIG  = TSC_DEFAULT_POST_TRIG
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       SBF,
   input  logic       rdy,
   input  logic [7:0] dat,
   output logic       req,
   output logic       CD,
   output logic       TRD,
   output logic       SD
);

   localparam int            AW        = $clog2(DEPTH);
   localparam logic [AW-1:0] POST_LAST = AW'(POST_TRIG - 1);
   localparam logic [AW-1:0] BYTE_LAST = AW'(DEPTH - 1);

   tscState_t     r_state;
   tscState_t     w_nextState;
   logic [AW-1:0] r_postCnt;
   logic [AW-1:0] r_byteCnt;
   logic [2:0]    r_bitCnt;
   logic [AW-1:0] w_wrPtr;
   logic [7:0]    w_rdData;
   logic          w_capture;
   logic          w_levelHit;
   logic          w_trigHit;
   logic          w_postDone;
   logic          w_sendLast;

   assign w_capture  = rdy && ((r_state == RUNNING) || (r_state == TRIGGERED));
   assign w_levelHit = (dat >= TRIG_LEVEL);
   assign w_postDone = (r_postCnt == POST_LAST);
   assign w_sendLast = (r_bitCnt == 3'd7) && (r_byteCnt == BYTE_LAST);

`ifdef TSC_EDGE_TRIG_EN
   logic [7:0] r_prevSample;

   // Remember the last stored sample so the trigger can demand a rising crossing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prevSample <= 8'h00;
      end else if (w_capture) begin
         r_prevSample <= dat;
      end
   end

   assign w_trigHit = w_levelHit && (r_prevSample < TRIG_LEVEL);
`else
   assign w_trigHit = w_levelHit;
`endif

   tsc_ring_buffer #(
      .DEPTH (DEPTH)
   ) u_ringBuffer (
      .clk        (clk),
      .reset      (reset),
      .i_wrEn     (w_capture),
      .i_wrData   (dat),
      .i_rdOffset (r_byteCnt),
      .o_wrPtr    (w_wrPtr),
      .o_rdData   (w_rdData)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode; start beats SBF in DONE, and SBF is only looked at there.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) w_nextState = RUNNING;
         end
         RUNNING: begin
            if (rdy && w_trigHit) begin
               w_nextState = (POST_TRIG == 1) ? DONE : TRIGGERED;
            end
         end
         TRIGGERED: begin
            if (rdy && w_postDone) w_nextState = DONE;
         end
         DONE: begin
            if (start)    w_nextState = RUNNING;
            else if (SBF) w_nextState = SENDING;
         end
         SENDING: begin
            if (w_sendLast) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Post-trigger count: the trigger sample itself is sample 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_postCnt <= '0;
      end else if (r_state == RUNNING) begin
         r_postCnt <= (rdy && w_trigHit) ? AW'(1) : '0;
      end else if ((r_state == TRIGGERED) && rdy) begin
         r_postCnt <= r_postCnt + AW'(1);
      end
   end

   // Serializer position: bit within byte, then byte offset from the oldest slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bitCnt  <= 3'd0;
         r_byteCnt <= '0;
      end else if (r_state == SENDING) begin
         r_bitCnt <= r_bitCnt + 3'd1;
         if (r_bitCnt == 3'd7) r_byteCnt <= r_byteCnt + AW'(1);
      end else begin
         r_bitCnt  <= 3'd0;
         r_byteCnt <= '0;
      end
   end

   // Moore outputs decoded from the state so reset clears them immediately.
   always_comb begin
      req = (r_state == RUNNING) || (r_state == TRIGGERED);
      CD  = (r_state == DONE) || (r_state == SENDING);
      TRD = (r_state == TRIGGERED) || (r_state == DONE) || (r_state == SENDING);
      SD  = (r_state == SENDING) && w_rdData[3'd7 - r_bitCnt];
   end

   // The pointer is only consumed inside the ring buffer's read addressing.
   logic w_unusedPtr;
   assign w_unusedPtr = ^w_wrPtr;

endmodule

// File: tb/tb_tsc.sv
// Directed self-checking bench for tsc with default parameters
// (DEPTH=32, TRIG_LEVEL=D0, POST_TRIG=16). Honours TSC_EDGE_TRIG_EN.
module tb_tsc;

   logic       clk;
   logic       reset;
   logic       start;
   logic       SBF;
   logic       rdy;
   logic [7:0] dat;
   logic       req;
   logic       CD;
   logic       TRD;
   logic       SD;

   int testCount;
   int failCount;

   logic [7:0] modelMem [32];
   logic [4:0] modelPtr;

   tsc dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .SBF   (SBF),
      .rdy   (rdy),
      .dat   (dat),
      .req   (req),
      .CD    (CD),
      .TRD   (TRD),
      .SD    (SD)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // One clock with the given rdy/dat; returns 1 unit after the edge.
   task automatic applyStimulus(input logic rdyVal, input logic [7:0] datVal);
      rdy = rdyVal;
      dat = datVal;
      @(posedge clk);
      #1;
      rdy = 1'b0;
   endtask

   // A sample the DUT is expected to store; mirrored into the bench buffer.
   task automatic pushSample(input logic [7:0] d);
      applyStimulus(1'b1, d);
      modelMem[modelPtr] = d;
      modelPtr = modelPtr + 5'd1;
   endtask

   initial begin
      logic [4:0] idx;
      logic       expBit;
      testCount = 0;
      failCount = 0;
      modelPtr  = 5'd0;
      reset = 1'b0;
      start = 1'b0;
      SBF   = 1'b0;
      rdy   = 1'b0;
      dat   = 8'h00;

      // Reset state.
      #12;
      checkOutput("reset_outputs", {28'd0, req, CD, TRD, SD}, 32'h0);
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00);
      checkOutput("idle_after_reset", {28'd0, req, CD, TRD, SD}, 32'h0);

      // Asynchronous reset in the middle of a capture.
      start = 1'b1;
      applyStimulus(1'b0, 8'h00);
      start = 1'b0;
      checkOutput("running_req", {31'd0, req}, 32'h1);
      applyStimulus(1'b1, 8'h11);
      applyStimulus(1'b1, 8'h12);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_reset_clears", {28'd0, req, CD, TRD, SD}, 32'h0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'hF0);
         checkOutput("stay_idle_no_start", {28'd0, req, CD, TRD, SD}, 32'h0);
      end

      // Long capture below the level; start/SBF held high must be ignored.
      start = 1'b1;
      applyStimulus(1'b0, 8'h00);
      SBF = 1'b1;
      for (int i = 0; i < 100; i++) begin
         pushSample(8'((i * 7) % 200));
         checkOutput("below_level", {29'd0, req, CD, TRD}, 32'h4);
      end
      start = 1'b0;
      SBF   = 1'b0;

      // Trigger sequence: D5 triggers and counts as post sample 1.
      pushSample(8'h00);
      pushSample(8'h0A);
      pushSample(8'h99);
      pushSample(8'h9B);
      pushSample(8'h93);
      checkOutput("no_trig_yet", {31'd0, TRD}, 32'h0);
      pushSample(8'hD5);
      checkOutput("trig_on_D5", {29'd0, req, CD, TRD}, 32'h5);
      for (int i = 1; i <= 10; i++) begin
         pushSample(8'(8'h20 + i));
         checkOutput("post_counting", {29'd0, req, CD, TRD}, 32'h5);
      end
      // rdy gap: nothing stored, done is delayed by exactly these cycles.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'hFF);
         checkOutput("rdy_gap", {29'd0, req, CD, TRD}, 32'h5);
      end
      for (int i = 11; i <= 14; i++) begin
         pushSample(8'(8'h20 + i));
         checkOutput("post_after_gap", {29'd0, req, CD, TRD}, 32'h5);
      end
      pushSample(8'h2F);
      checkOutput("capture_done", {29'd0, req, CD, TRD}, 32'h3);
      applyStimulus(1'b1, 8'hEE);
      checkOutput("rdy_ignored_done", {29'd0, req, CD, TRD}, 32'h3);

      // Serial dump, oldest byte first, MSB first; SBF dropped during sending.
      SBF = 1'b1;
      applyStimulus(1'b0, 8'h00);
      SBF = 1'b0;
      for (int k = 0; k < 256; k++) begin
         idx    = modelPtr + 5'(k / 8);
         expBit = modelMem[idx][7 - (k % 8)];
         checkOutput($sformatf("sd_bit%0d", k), {31'd0, SD}, {31'd0, expBit});
         if (k == 100) checkOutput("cd_while_send", {31'd0, CD}, 32'h1);
         applyStimulus(1'b0, 8'h00);
      end
      checkOutput("idle_after_send", {28'd0, req, CD, TRD, SD}, 32'h0);

      // Second capture, ending on a high sample.
      start = 1'b1;
      applyStimulus(1'b0, 8'h00);
      start = 1'b0;
      pushSample(8'hE0);
      checkOutput("trig_on_E0", {29'd0, req, CD, TRD}, 32'h5);
      for (int i = 0; i < 14; i++) pushSample(8'h30);
      checkOutput("before_last_post", {31'd0, CD}, 32'h0);
      pushSample(8'hF0);
      checkOutput("second_done", {29'd0, req, CD, TRD}, 32'h3);

      // start beats SBF in DONE and restarts capture with CD/TRD cleared.
      start = 1'b1;
      SBF   = 1'b1;
      applyStimulus(1'b0, 8'h00);
      start = 1'b0;
      SBF   = 1'b0;
      checkOutput("restart_priority", {28'd0, req, CD, TRD, SD}, 32'h8);

      // Previous stored sample F0 is above the level.
      pushSample(8'hD7);
`ifdef TSC_EDGE_TRIG_EN
      checkOutput("edge_no_trig_D7", {31'd0, TRD}, 32'h0);
`else
      checkOutput("level_trig_D7", {31'd0, TRD}, 32'h1);
`endif
      pushSample(8'h99);
`ifdef TSC_EDGE_TRIG_EN
      checkOutput("edge_no_trig_99", {31'd0, TRD}, 32'h0);
`else
      checkOutput("level_hold_99", {31'd0, TRD}, 32'h1);
`endif
      pushSample(8'hD7);
      checkOutput("trig_after_99_D7", {29'd0, req, CD, TRD}, 32'h5);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
